// File: rtl/sreg_pipe_if.sv
// Handshake bundle for sreg_pipe: producer side (in_valid/in_ready/d) and
// consumer side (out_valid/out_ready/q) plus the live occupancy count.
interface sreg_pipe_if #(
    parameter int DATAWIDTH = 8,
    parameter int IN_WIDTH  = 8,
    parameter int DEPTH     = 4
);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic                        in_valid;
    logic                        in_ready;
    logic signed [IN_WIDTH-1:0]  d;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [DATAWIDTH-1:0] q;
    logic [CNTW-1:0]             occupancy;

    modport master (
        output in_valid, d, out_ready,
        input  in_ready, out_valid, q, occupancy
    );

    modport slave (
        input  in_valid, d, out_ready,
        output in_ready, out_valid, q, occupancy
    );
endinterface

// File: rtl/sreg_pipe.sv
// Elastic signed delay line: DEPTH register stages with per-stage valid bits,
// valid/ready backpressure, bubble collapse and a synchronous flush (Clr).
module sreg_pipe #(
    parameter int DATAWIDTH = 8,
    parameter int IN_WIDTH  = 8,
    parameter int DEPTH     = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Clr,
    sreg_pipe_if.slave bus
);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            v_r;
    logic signed [DATAWIDTH-1:0] data_r    [DEPTH];
    logic [DEPTH-1:0]            rdy_s;
    logic [DEPTH-1:0]            up_v_s;
    logic signed [DATAWIDTH-1:0] up_data_s [DEPTH];
    logic signed [DATAWIDTH-1:0] d_ext_s;

    function automatic logic [CNTW-1:0] popcount(input logic [DEPTH-1:0] vec);
        logic [CNTW-1:0] cnt;
        cnt = {CNTW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + CNTW'(vec[i]);
        end
        return cnt;
    endfunction

    // The size cast keeps the signedness of d, so this replicates its MSB.
    assign d_ext_s = DATAWIDTH'(bus.d);

    // Ready ripples from the consumer back to stage 0; an empty stage is always ready.
    always_comb begin
        logic chain_s;
        rdy_s   = {DEPTH{1'b0}};
        chain_s = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain_s  = ~v_r[i] | chain_s;
            rdy_s[i] = chain_s;
        end
    end

    // Upstream view of every stage: stage 0 sees the input port, others their predecessor.
    always_comb begin
        up_v_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            up_data_s[i] = {DATAWIDTH{1'b0}};
        end
        up_v_s[0]    = bus.in_valid;
        up_data_s[0] = d_ext_s;
        for (int i = 1; i < DEPTH; i++) begin
            up_v_s[i]    = v_r[i-1];
            up_data_s[i] = data_r[i-1];
        end
    end

    // Stage state: async reset, synchronous flush, otherwise advance where ready and hold where stalled.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            v_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= {DATAWIDTH{1'b0}};
            end
        end else if (Clr) begin
            v_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= {DATAWIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy_s[i]) begin
                    v_r[i] <= up_v_s[i];
                    // A bubble moving in keeps the old payload; only valid samples overwrite it.
                    if (up_v_s[i]) begin
                        data_r[i] <= up_data_s[i];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = rdy_s[0] & ~Clr;
    assign bus.out_valid = v_r[DEPTH-1];
    assign bus.q         = data_r[DEPTH-1];
    assign bus.occupancy = popcount(v_r);

endmodule

// File: tb/tb_sreg_pipe.sv
// Self-checking bench for sreg_pipe: five configurations checked every cycle
// against a positional queue model, plus a vector table and directed corner cases.
module tb_sreg_pipe;
    localparam int NDUT = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv   [NDUT];
    logic        ordy [NDUT];
    logic        clr  [NDUT];
    logic [31:0] din  [NDUT];

    logic [31:0] act_ir  [NDUT];
    logic [31:0] act_ov  [NDUT];
    logic [31:0] act_q   [NDUT];
    logic [31:0] act_occ [NDUT];

    int dep [NDUT];
    int inw [NDUT];

    // Model: samples oldest first, with their payload and current stage index.
    int md   [NDUT][16];
    int mp   [NDUT][16];
    int mcnt [NDUT];
    bit pop_e  [NDUT];
    bit push_e [NDUT];

    int n_vec = 0;
    int n_err = 0;

    sreg_pipe_if #(.DATAWIDTH(8),  .IN_WIDTH(4), .DEPTH(4)) if0 ();
    sreg_pipe_if #(.DATAWIDTH(8),  .IN_WIDTH(8), .DEPTH(4)) if1 ();
    sreg_pipe_if #(.DATAWIDTH(8),  .IN_WIDTH(8), .DEPTH(1)) if2 ();
    sreg_pipe_if #(.DATAWIDTH(8),  .IN_WIDTH(5), .DEPTH(3)) if3 ();
    sreg_pipe_if #(.DATAWIDTH(12), .IN_WIDTH(8), .DEPTH(8)) if4 ();

    sreg_pipe #(.DATAWIDTH(8),  .IN_WIDTH(4), .DEPTH(4)) dut0 (.Clk(clk), .Rst(rst), .Clr(clr[0]), .bus(if0));
    sreg_pipe #(.DATAWIDTH(8),  .IN_WIDTH(8), .DEPTH(4)) dut1 (.Clk(clk), .Rst(rst), .Clr(clr[1]), .bus(if1));
    sreg_pipe #(.DATAWIDTH(8),  .IN_WIDTH(8), .DEPTH(1)) dut2 (.Clk(clk), .Rst(rst), .Clr(clr[2]), .bus(if2));
    sreg_pipe #(.DATAWIDTH(8),  .IN_WIDTH(5), .DEPTH(3)) dut3 (.Clk(clk), .Rst(rst), .Clr(clr[3]), .bus(if3));
    sreg_pipe #(.DATAWIDTH(12), .IN_WIDTH(8), .DEPTH(8)) dut4 (.Clk(clk), .Rst(rst), .Clr(clr[4]), .bus(if4));

    assign if0.in_valid = iv[0]; assign if0.d = din[0][3:0]; assign if0.out_ready = ordy[0];
    assign if1.in_valid = iv[1]; assign if1.d = din[1][7:0]; assign if1.out_ready = ordy[1];
    assign if2.in_valid = iv[2]; assign if2.d = din[2][7:0]; assign if2.out_ready = ordy[2];
    assign if3.in_valid = iv[3]; assign if3.d = din[3][4:0]; assign if3.out_ready = ordy[3];
    assign if4.in_valid = iv[4]; assign if4.d = din[4][7:0]; assign if4.out_ready = ordy[4];

    assign act_ir[0] = 32'(if0.in_ready); assign act_ov[0] = 32'(if0.out_valid);
    assign act_q[0]  = 32'(if0.q);        assign act_occ[0] = 32'(if0.occupancy);
    assign act_ir[1] = 32'(if1.in_ready); assign act_ov[1] = 32'(if1.out_valid);
    assign act_q[1]  = 32'(if1.q);        assign act_occ[1] = 32'(if1.occupancy);
    assign act_ir[2] = 32'(if2.in_ready); assign act_ov[2] = 32'(if2.out_valid);
    assign act_q[2]  = 32'(if2.q);        assign act_occ[2] = 32'(if2.occupancy);
    assign act_ir[3] = 32'(if3.in_ready); assign act_ov[3] = 32'(if3.out_valid);
    assign act_q[3]  = 32'(if3.q);        assign act_occ[3] = 32'(if3.occupancy);
    assign act_ir[4] = 32'(if4.in_ready); assign act_ov[4] = 32'(if4.out_valid);
    assign act_q[4]  = 32'(if4.q);        assign act_occ[4] = 32'(if4.occupancy);

    typedef struct {
        logic       iv;
        logic [3:0] d;
        logic       ordy;
        int         ir;
        int         ov;
        int         q;
        int         occ;
    } vec_t;

    localparam int NTBL = 20;
    vec_t tbl [NTBL];

    function automatic int sext(input logic [31:0] x, input int w);
        int r;
        r = int'(x & ((32'd1 << w) - 32'd1));
        if (r >= (1 << (w - 1))) r = r - (1 << w);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic check_models();
        for (int k = 0; k < NDUT; k++) begin
            int ev;
            int eir;
            ev  = (mcnt[k] > 0 && mp[k][0] == dep[k] - 1) ? 1 : 0;
            eir = ((mcnt[k] < dep[k] || ordy[k] === 1'b1) && clr[k] !== 1'b1) ? 1 : 0;
            chk($sformatf("dut%0d in_ready", k),  act_ir[k],  eir);
            chk($sformatf("dut%0d out_valid", k), act_ov[k],  ev);
            chk($sformatf("dut%0d occupancy", k), act_occ[k], mcnt[k]);
            if (ev == 1) chk($sformatf("dut%0d q", k), act_q[k], md[k][0]);
            pop_e[k]  = (ev == 1) && ordy[k] === 1'b1;
            push_e[k] = (eir == 1) && iv[k] === 1'b1;
        end
    endtask

    task automatic update_models();
        for (int k = 0; k < NDUT; k++) begin
            if (clr[k] === 1'b1) begin
                mcnt[k] = 0;
            end else begin
                int lim;
                if (pop_e[k]) begin
                    for (int j = 0; j < mcnt[k] - 1; j++) begin
                        md[k][j] = md[k][j+1];
                        mp[k][j] = mp[k][j+1];
                    end
                    mcnt[k]--;
                end
                // Each sample moves one stage on, but never onto the one ahead of it.
                lim = dep[k] - 1;
                for (int j = 0; j < mcnt[k]; j++) begin
                    mp[k][j] = (mp[k][j] + 1 < lim) ? mp[k][j] + 1 : lim;
                    lim = mp[k][j] - 1;
                end
                if (push_e[k]) begin
                    md[k][mcnt[k]] = sext(din[k], inw[k]);
                    mp[k][mcnt[k]] = 0;
                    mcnt[k]++;
                end
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        check_models();
    endtask

    task automatic edge_();
        @(posedge clk);
        update_models();
        #1;
    endtask

    task automatic tick();
        half();
        edge_();
    endtask

    task automatic drive1(input logic v, input int val, input logic r);
        iv[1]   = v;
        din[1]  = 32'(val);
        ordy[1] = r;
    endtask

    initial begin
        dep = '{4, 4, 1, 3, 8};
        inw = '{4, 8, 8, 5, 8};
        for (int k = 0; k < NDUT; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; clr[k] = 1'b0; din[k] = 32'd0; mcnt[k] = 0;
        end

        tbl[0]  = '{1'b1, 4'b1001, 1'b1, 1, 0,  0, 0};
        tbl[1]  = '{1'b1, 4'b0111, 1'b1, 1, 0,  0, 1};
        tbl[2]  = '{1'b0, 4'd0,    1'b1, 1, 0,  0, 2};
        tbl[3]  = '{1'b0, 4'd0,    1'b1, 1, 0,  0, 2};
        tbl[4]  = '{1'b0, 4'd0,    1'b1, 1, 1, -7, 2};
        tbl[5]  = '{1'b0, 4'd0,    1'b1, 1, 1,  7, 1};
        tbl[6]  = '{1'b0, 4'd0,    1'b1, 1, 0,  7, 0};
        tbl[7]  = '{1'b1, 4'd1,    1'b0, 1, 0,  7, 0};
        tbl[8]  = '{1'b1, 4'd2,    1'b0, 1, 0,  7, 1};
        tbl[9]  = '{1'b1, 4'd3,    1'b0, 1, 0,  7, 2};
        tbl[10] = '{1'b1, 4'd4,    1'b0, 1, 0,  7, 3};
        tbl[11] = '{1'b1, 4'd5,    1'b0, 0, 1,  1, 4};
        tbl[12] = '{1'b1, 4'd5,    1'b0, 0, 1,  1, 4};
        tbl[13] = '{1'b1, 4'd5,    1'b1, 1, 1,  1, 4};
        tbl[14] = '{1'b1, 4'd6,    1'b1, 1, 1,  2, 4};
        tbl[15] = '{1'b0, 4'd0,    1'b1, 1, 1,  3, 4};
        tbl[16] = '{1'b0, 4'd0,    1'b1, 1, 1,  4, 3};
        tbl[17] = '{1'b0, 4'd0,    1'b1, 1, 1,  5, 2};
        tbl[18] = '{1'b0, 4'd0,    1'b1, 1, 1,  6, 1};
        tbl[19] = '{1'b0, 4'd0,    1'b1, 1, 0,  6, 0};

        rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) chk($sformatf("dut%0d reset q", k), act_q[k], 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Sign extension and backpressure on the 4-bit-input pipeline.
        for (int i = 0; i < NTBL; i++) begin
            iv[0]   = tbl[i].iv;
            din[0]  = {28'd0, tbl[i].d};
            ordy[0] = tbl[i].ordy;
            half();
            chk($sformatf("tbl%0d in_ready", i),  act_ir[0],  tbl[i].ir);
            chk($sformatf("tbl%0d out_valid", i), act_ov[0],  tbl[i].ov);
            chk($sformatf("tbl%0d q", i),         act_q[0],   tbl[i].q);
            chk($sformatf("tbl%0d occupancy", i), act_occ[0], tbl[i].occ);
            edge_();
        end
        iv[0] = 1'b0;

        // Asynchronous reset while full.
        for (int i = 0; i < 4; i++) begin
            drive1(1'b1, 10 * (i + 1), 1'b0);
            tick();
        end
        drive1(1'b0, 0, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async reset q", act_q[1], 32'd0);
        chk("async reset out_valid", act_ov[1], 32'd0);
        chk("async reset occupancy", act_occ[1], 32'd0);
        rst = 1'b0;
        for (int k = 0; k < NDUT; k++) mcnt[k] = 0;
        half();
        chk("post reset in_ready", act_ir[1], 32'd1);
        edge_();

        // Bubble collapse: -3, two idle cycles, 9, consumer stalled.
        drive1(1'b1, -3, 1'b0); tick();
        drive1(1'b0, 0, 1'b0);  tick(); tick();
        drive1(1'b1, 9, 1'b0);  tick();
        drive1(1'b0, 0, 1'b0);  tick(); tick(); tick();
        half();
        chk("bubble out_valid", act_ov[1], 32'd1);
        chk("bubble q", act_q[1], -32'sd3);
        chk("bubble occupancy", act_occ[1], 32'd2);
        edge_();
        ordy[1] = 1'b1;
        half();
        chk("bubble first out", act_q[1], -32'sd3);
        edge_();
        half();
        chk("bubble second out", act_q[1], 32'd9);
        edge_();
        tick();

        // Flush a full pipeline with a sample offered and an output taken in the same cycle.
        for (int i = 0; i < 4; i++) begin
            drive1(1'b1, i + 1, 1'b0);
            tick();
        end
        drive1(1'b1, 99, 1'b1);
        clr[1] = 1'b1;
        half();
        chk("flush in_ready", act_ir[1], 32'd0);
        edge_();
        clr[1] = 1'b0;
        drive1(1'b0, 0, 1'b1);
        half();
        chk("flush occupancy", act_occ[1], 32'd0);
        chk("flush out_valid", act_ov[1], 32'd0);
        chk("flush q", act_q[1], 32'd0);
        edge_();
        for (int i = 0; i < 6; i++) tick();

        // Random stress on every configuration at once.
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < NDUT; k++) begin
                iv[k]   = 1'($urandom_range(0, 1));
                ordy[k] = 1'($urandom_range(0, 1));
                din[k]  = $urandom;
                clr[k]  = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sreg_pipe.md
# sreg_pipe

Parametrised signed elastic pipeline register: a chain of DEPTH signed register stages with per-stage valid bits and valid/ready backpressure, so data can be delayed a fixed number of cycles without losing samples when the consumer stalls. Input samples of IN_WIDTH bits are sign-extended to DATAWIDTH at entry. It replaces bare single-stage signed registers in datapaths that need multi-cycle retiming, stall tolerance, occupancy visibility and a synchronous flush.

## Interface
- DATAWIDTH, 8, width of stored/output signed data.
- IN_WIDTH, 8, width of signed input `d`; must satisfy 1 ≤ IN_WIDTH ≤ DATAWIDTH.
- DEPTH, 4, number of register stages; DEPTH ≥ 1.
- CNTW, $clog2(DEPTH+1), occupancy output width (derived, not overridden).

- Clk  in  1  clock, all state on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Clr  in  1  synchronous flush of all stages.
- in_valid  in  1  producer has a sample on `d`.
- in_ready  out  1  pipeline accepts `d` this cycle.
- d  in  IN_WIDTH  signed input sample.
- out_valid  out  1  stage DEPTH-1 holds a valid sample.
- out_ready  in  1  consumer accepts `q` this cycle.
- q  out  DATAWIDTH  signed output sample (stage DEPTH-1 data).
- occupancy  out  CNTW  number of valid stages, 0..DEPTH.

## Operation
- Stages indexed 0 (input) to DEPTH-1 (output); each holds `v[i]` and signed `data[i]`.
- Ready chain (combinational): `rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready`; `rdy[i] = ~v[i] | rdy[i+1]`.
- `in_ready = rdy[0] & ~Clr`.
- Input transfer: `in_valid & in_ready`. Output transfer: `out_valid & out_ready`.
- On a rising edge with Clr=0, each stage with `rdy[i]=1` loads: `v[i] <= upstream valid` (in_valid for stage 0, `v[i-1]` otherwise); `data[i]` updates only when upstream valid is 1, else holds.
- Stage 0 data = `d` sign-extended (replicate `d[IN_WIDTH-1]`) to DATAWIDTH; no other arithmetic.
- Stages with `rdy[i]=0` hold `v` and `data` (stall).
- Bubbles collapse: an empty stage loads even while downstream stalls.
- Clr=1: all `v` ← 0, all `data` ← 0 on the edge; input dropped; an output transfer in the same cycle still counts for the consumer, nothing is kept.
- `occupancy` = popcount of `v`, registered-consistent (computed from current `v`, combinational).
- `q = data[DEPTH-1]`, `out_valid = v[DEPTH-1]`; q is held stable while out_valid=1 and out_ready=0.

## Timing
- Rst asserted: immediately all `v`=0, all `data`=0; outputs q=0, out_valid=0, occupancy=0; in_ready=1 (if Clr=0).
- Rst mid-operation discards all in-flight samples; no partial state survives.
- Latency with no stalls: sample accepted at edge N appears on q with out_valid=1 after edge N+DEPTH-1 (DEPTH cycles input-to-output registration, first registration at acceptance edge).
- Throughput: one sample per cycle when out_ready=1 continuously.
- Full (occupancy=DEPTH) and out_ready=0: in_ready=0, no state changes.
- Full and out_ready=1: in_ready=1; simultaneous accept and emit, occupancy unchanged.
- Empty: out_valid=0; out_ready ignored.
- DEPTH=1: behaves as a single signed register with handshake; in_ready = ~v[0] | out_ready.
- Combinational path out_ready → in_ready spans DEPTH stages (accepted; no skid buffer).

## Test plan
- Reset/defaults: assert Rst asynchronously mid-cycle with pipeline full -> q=0, out_valid=0, occupancy=0 before next edge; in_ready=1 after release.
- Sign extension (IN_WIDTH=4, DATAWIDTH=8, DEPTH=4): stream d=4'b1001, 4'b0111, out_ready=1 -> q=8'hF9 (−7) then 8'h07, each exactly 4 cycles after acceptance.
- Backpressure: DEPTH=4, push 1,2,3,4,5,6 with out_ready=0 -> in_ready drops after 4 accepts, occupancy=4, q=1 held; release out_ready -> outputs 1..6 in order, no loss or duplication.
- Bubble collapse: send sample −3, idle 2 cycles, send 9, with out_ready=0 -> both packed into stages 3 and 2, occupancy=2.
- Flush: full pipeline, pulse Clr one cycle with in_valid=1 -> in_ready=0 that cycle, next cycle occupancy=0, out_valid=0, q=0; input during Clr never appears.
- Random stress: random in_valid/out_ready at 50% for 10k cycles, DEPTH∈{1,3,8} -> scoreboard order matches, occupancy = accepted − emitted at every edge.
